afe_spi_arbiter: RTL and testbench

- Shares one afeSPI serial engine between NREQ independent requesters, e.g. software CSR, AFE attenuator updater and PLL init sequencer.
- Requests are granted round-robin and issued as one afeSPI CSR-write command each.
- The busy bit is tracked through start and finish, then a completion pulse and readback data go back to the owner.
- Sits between the requester logic and the afeSPI csrStrobe/gpioOut/status ports.

---
 rtl/afe_spi_arb_pkg.sv | 30 +++
 rtl/afe_spi_arbiter_rr_pick.sv | 35 +++
 rtl/afe_spi_arbiter.sv | 160 ++++++++++++++++
 tb/tb_afe_spi_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/afe_spi_arb_pkg.sv
// afe_spi_arb_pkg: shared constants, FSM state encoding and counter sizing
// for the afeSPI request arbiter.
//   CMD_*          : field positions inside the 32-bit afeSPI command word
//   STATUS_BUSY_BIT: busy flag position in the afeSPI status word
//   arb_state_e    : arbiter FSM states
//   wait_cnt_width : width of a counter that must count 0..max(a,b)-1
package afe_spi_arb_pkg;

  localparam int unsigned CMD_24BIT_OP_BIT  = 31;
  localparam int unsigned CMD_LSB_FIRST_BIT = 30;
  localparam int unsigned CMD_DEVSEL_SHIFT  = 24;
  localparam int unsigned CMD_DEVSEL_WIDTH  = 4;
  localparam int unsigned STATUS_BUSY_BIT   = 31;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_FINISH     = 3'd4
  } arb_state_e;

  function automatic int unsigned wait_cnt_width(input int unsigned a,
                                                 input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/afe_spi_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req_i    : request vector
//   ptr_i    : index with highest priority this round
//   winner_o : one-hot winner (first request at or after ptr_i, wrapping)
//   idx_o    : binary index of the winner
//   valid_o  : at least one request present
module rr_pick #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         winner_o,
  output logic [$clog2(NREQ)-1:0] idx_o,
  output logic                    valid_o
);

  localparam int unsigned IW = $clog2(NREQ);

  always_comb begin
    int unsigned pos;
    winner_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    pos      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = (int'(ptr_i) + k) % NREQ;
      if (!valid_o && req_i[pos]) begin
        valid_o       = 1'b1;
        winner_o[pos] = 1'b1;
        idx_o         = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/afe_spi_arbiter.sv
// afe_spi_arbiter: shares one afeSPI engine between NREQ requesters,
// round-robin, one CSR-write command per grant.
//   clk, rst    : clock, synchronous active-high reset
//   req, cmd    : per-requester level request and 32-bit command word
//   ack, err    : one-cycle completion pulse to owner, failure qualifier
//   rdata       : status[23:0] captured at completion, valid with ack
//   grant       : one-hot current owner, zero when idle
//   spiStrobe   : csrStrobe to afeSPI
//   spiCommand  : gpioOut to afeSPI
//   spiStatus   : status from afeSPI, bit31 busy
// Build option AFE_SPI_ARBITER_DONE_TIMEOUT_EN bounds the busy phase to
// DONE_WAIT cycles; without it only the start phase can time out.
module afe_spi_arbiter
  import afe_spi_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned START_WAIT = 16,
  parameter int unsigned DONE_WAIT  = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*32-1:0] cmd,
  output logic [NREQ-1:0]    ack,
  output logic               err,
  output logic [23:0]        rdata,
  output logic [NREQ-1:0]    grant,
  output logic               spiStrobe,
  output logic [31:0]        spiCommand,
  input  logic [31:0]        spiStatus
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = wait_cnt_width(START_WAIT, DONE_WAIT);

  arb_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic            fail_q, fail_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [31:0]     cmd_q, cmd_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            err_q, err_d;
  logic [23:0]     rdata_q, rdata_d;

  logic            busy;
  logic [NREQ-1:0] win;
  logic [IW-1:0]   win_idx;
  logic            win_valid;
  logic            unused_status;

  assign busy          = spiStatus[STATUS_BUSY_BIT];
  assign unused_status = ^spiStatus[30:24];

  // The just-acked requester still shows req during its ack cycle; masking
  // it stops a spurious re-grant before it has had a chance to drop req.
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i    (req & ~ack_q),
    .ptr_i    (ptr_q),
    .winner_o (win),
    .idx_o    (win_idx),
    .valid_o  (win_valid)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    fail_d  = fail_q;
    grant_d = grant_q;
    cmd_d   = cmd_q;
    ack_d   = '0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_valid && !busy) begin
          state_d = ST_ISSUE;
          grant_d = win;
          owner_d = win_idx;
          cmd_d   = cmd[int'(win_idx)*32 +: 32];
          fail_d  = 1'b0;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_START;
        cnt_d   = '0;
      end
      ST_WAIT_START: begin
        if (busy) begin
          state_d = ST_WAIT_DONE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(START_WAIT - 1)) begin
          state_d = ST_FINISH;
          fail_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!busy) begin
          state_d = ST_FINISH;
        end
`ifdef AFE_SPI_ARBITER_DONE_TIMEOUT_EN
        else if (cnt_q == CW'(DONE_WAIT - 1)) begin
          state_d = ST_FINISH;
          fail_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_FINISH: begin
        ack_d   = grant_q;
        err_d   = fail_q;
        rdata_d = spiStatus[23:0];
        ptr_d   = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      fail_q  <= 1'b0;
      grant_q <= '0;
      cmd_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      fail_q  <= fail_d;
      grant_q <= grant_d;
      cmd_q   <= cmd_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign ack        = ack_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign grant      = grant_q;
  assign spiStrobe  = (state_q == ST_ISSUE);
  assign spiCommand = cmd_q;

endmodule

// File: tb/tb_afe_spi_arbiter.sv
// tb_afe_spi_arbiter: directed bench for afe_spi_arbiter with a small
// afeSPI engine stand-in (busy rises 3 cycles after the strobe, status
// data = command[23:0] ^ 0x5A5A5A).
module tb_afe_spi_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned SW   = 16;
  localparam int unsigned DW   = 40;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*32-1:0] cmd;
  logic [NREQ-1:0]   ack;
  logic              err;
  logic [23:0]       rdata;
  logic [NREQ-1:0]   grant;
  logic              spiStrobe;
  logic [31:0]       spiCommand;
  logic [31:0]       spiStatus;

  afe_spi_arbiter #(.NREQ(NREQ), .START_WAIT(SW), .DONE_WAIT(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .cmd        (cmd),
    .ack        (ack),
    .err        (err),
    .rdata      (rdata),
    .grant      (grant),
    .spiStrobe  (spiStrobe),
    .spiCommand (spiCommand),
    .spiStatus  (spiStatus)
  );

  always #5 clk = ~clk;

  // engine stand-in: mode 0 normal, 1 never goes busy, 2 busy stuck high
  int          eng_mode  = 0;
  int          eng_delay = 0;
  int          eng_left  = 0;
  logic        busy      = 1'b0;
  logic [23:0] eng_data  = '0;
  assign spiStatus = {busy, 7'd0, eng_data};

  always @(posedge clk) begin
    if (spiStrobe) begin
      eng_data <= spiCommand[23:0] ^ 24'h5A5A5A;
      if (eng_mode != 1) eng_delay <= 2;
    end else if (eng_delay != 0) begin
      eng_delay <= eng_delay - 1;
      if (eng_delay == 1) begin
        busy     <= 1'b1;
        eng_left <= 20;
      end
    end else if (busy && eng_mode == 0) begin
      eng_left <= eng_left - 1;
      if (eng_left == 1) busy <= 1'b0;
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned strobe_cnt = 0;
  int unsigned last_strobe_cyc = 0;
  int unsigned viol_sb = 0;
  int unsigned viol_gr = 0;
  logic [NREQ-1:0] grant_log[$];

  always @(negedge clk) begin
    if (spiStrobe) begin
      strobe_cnt      <= strobe_cnt + 1;
      last_strobe_cyc <= cyc;
      grant_log.push_back(grant);
      if (busy) viol_sb <= viol_sb + 1;
    end
    if ($countones(grant) > 1) viol_gr <= viol_gr + 1;
  end

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_strobe(input int unsigned limit);
    int unsigned snap;
    bit seen;
    snap = strobe_cnt;
    seen = 1'b0;
    for (int unsigned i = 0; i < limit && !seen; i++) begin
      tick();
      if (strobe_cnt != snap) seen = 1'b1;
    end
    if (!seen) check("strobe_wait_timeout", 32'(strobe_cnt - snap), 32'd1);
  endtask

  task automatic wait_ack(input int unsigned limit, output int unsigned at);
    bit seen;
    seen = 1'b0;
    at   = 0;
    for (int unsigned i = 0; i < limit && !seen; i++) begin
      tick();
      if (ack != '0) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
    if (!seen) check("ack_wait_timeout", 32'(ack), 32'd1);
  endtask

  logic [23:0]     t2_rdata [4] = '{24'h5A5A5A, 24'h5A5A5B, 24'h5A5A58, 24'h5A5A59};
  logic [NREQ-1:0] t2_order [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    int unsigned t, c0, s0, s, n;
    rst = 1'b1;
    req = '0;
    cmd = '0;
    repeat (3) tick();
    check("rst_ack",    32'(ack),   32'h0);
    check("rst_err",    32'(err),   32'h0);
    check("rst_rdata",  32'(rdata), 32'h0);
    check("rst_grant",  32'(grant), 32'h0);
    check("rst_strobe", 32'(spiStrobe), 32'h0);
    check("rst_cmd",    spiCommand, 32'h0);
    rst = 1'b0;
    tick();

    // single request from slot 0
    cmd[31:0] = 32'h400007AA;
    req = 4'b0001;
    c0 = cyc;
    s0 = strobe_cnt;
    wait_strobe(10);
    check("t1_strobe_lat", 32'(last_strobe_cyc - c0), 32'd1);
    check("t1_cmd",   spiCommand, 32'h400007AA);
    check("t1_grant", 32'(grant), 32'h1);
    wait_ack(200, t);
    check("t1_ack",   32'(ack),   32'h1);
    check("t1_err",   32'(err),   32'h0);
    check("t1_rdata", 32'(rdata), 32'h5A5DF0);
    req = '0;
    tick();
    check("t1_ack_pulse", 32'(ack),   32'h0);
    check("t1_grant_clr", 32'(grant), 32'h0);
    check("t1_one_strobe", 32'(strobe_cnt - s0), 32'd1);
    check("t1_cmd_hold", spiCommand, 32'h400007AA);

    // all four at once after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmd = {32'h13000003, 32'h12000002, 32'h11000001, 32'h10000000};
    grant_log.delete();
    req = 4'hF;
    for (int k = 0; k < 4; k++) begin
      wait_ack(200, t);
      check($sformatf("t2_ack%0d", k), 32'(ack), 32'(t2_order[k]));
      check($sformatf("t2_rdata%0d", k), 32'(rdata), 32'(t2_rdata[k]));
      req[k] = 1'b0;
    end
    check("t2_strobes", 32'(grant_log.size()), 32'd4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      check($sformatf("t2_order%0d", k), 32'(grant_log[k]), 32'(t2_order[k]));

    // fairness: 1 held, 2 joins mid-transfer
    cmd[63:32] = 32'h21000011;
    cmd[95:64] = 32'h22000022;
    req = 4'b0010;
    wait_strobe(10);
    repeat (5) tick();
    req[2] = 1'b1;
    wait_ack(200, t);
    check("t3_ack_first", 32'(ack), 32'h2);
    wait_ack(200, t);
    check("t3_ack_second", 32'(ack),   32'h4);
    check("t3_rdata",      32'(rdata), 32'h5A5A78);
    req[2] = 1'b0;
    wait_ack(200, t);
    check("t3_ack_third", 32'(ack), 32'h2);
    req = '0;
    tick();

    // start timeout: engine never goes busy
    eng_mode = 1;
    cmd[127:96] = 32'h8A123456;
    req = 4'b1000;
    wait_strobe(10);
    s = last_strobe_cyc;
    wait_ack(100, t);
    check("t4_ack",   32'(ack),   32'h8);
    check("t4_err",   32'(err),   32'h1);
    check("t4_lat",   32'(t - s), 32'(SW + 2));
    check("t4_rdata", 32'(rdata), 32'h486E0C);
    req = '0;
    eng_mode = 0;
    tick();
    req = 4'b0001;
    wait_ack(200, t);
    check("t4_next_ack", 32'(ack), 32'h1);
    check("t4_next_err", 32'(err), 32'h0);
    req = '0;
    tick();

    // reset in WAIT_DONE with busy stuck
    eng_mode = 2;
    cmd[95:64] = 32'h0F00ABCD;
    req = 4'b0100;
    wait_strobe(10);
    repeat (10) tick();
    check("t5_grant_busy", 32'(grant), 32'h4);
    rst = 1'b1;
    tick();
    check("t5_ack",    32'(ack),   32'h0);
    check("t5_err",    32'(err),   32'h0);
    check("t5_rdata",  32'(rdata), 32'h0);
    check("t5_grant",  32'(grant), 32'h0);
    check("t5_strobe", 32'(spiStrobe), 32'h0);
    check("t5_cmd",    spiCommand, 32'h0);
    rst = 1'b0;
    s = strobe_cnt;
    repeat (30) tick();
    check("t5_hold_busy", 32'(strobe_cnt - s), 32'd0);
    eng_mode = 0;
    wait_ack(200, t);
    check("t5_ack_after", 32'(ack),   32'h4);
    check("t5_err_after", 32'(err),   32'h0);
    check("t5_rdata_aft", 32'(rdata), 32'h5AF197);
    req = '0;
    tick();

    // busy stuck high after start
    eng_mode = 2;
    req = 4'b0010;
    wait_strobe(10);
    s = last_strobe_cyc;
`ifdef AFE_SPI_ARBITER_DONE_TIMEOUT_EN
    wait_ack(DW + 50, t);
    check("t6_ack",   32'(ack),   32'h2);
    check("t6_err",   32'(err),   32'h1);
    check("t6_lat",   32'(t - s), 32'(DW + 5));
    req = 4'b0001;
    s = strobe_cnt;
    repeat (30) tick();
    check("t6_hold_busy", 32'(strobe_cnt - s), 32'd0);
    eng_mode = 0;
    wait_ack(200, t);
    check("t6_next_ack", 32'(ack), 32'h1);
    check("t6_next_err", 32'(err), 32'h0);
`else
    n = 0;
    repeat (DW + 50) begin
      tick();
      if (ack != '0) n++;
    end
    check("t6_no_ack", 32'(n), 32'd0);
    eng_mode = 0;
    wait_ack(200, t);
    check("t6_late_ack", 32'(ack), 32'h2);
    check("t6_late_err", 32'(err), 32'h0);
`endif
    req = '0;
    repeat (3) tick();

    check("no_strobe_while_busy", 32'(viol_sb), 32'd0);
    check("grant_onehot",         32'(viol_gr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1, "watchdog");
  end

endmodule
